// File: rtl/wb_pkg.sv
// Shared types and defaults for the Wishbone classic master bridge.
package wb_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'b001,
    TRAN    = 3'b010,
    ENDTRAN = 3'b100
  } wb_state_e;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 32;

  function automatic int sel_width(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/wb_timeout_cnt.sv
// Saturating cycle counter with synchronous clear; flags when LIMIT is reached.
module wb_timeout_cnt #(
  parameter  int LIMIT = 255,
  localparam int CNT_W = $clog2(LIMIT + 1)
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic reached_o
);

  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LIMIT_C)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign reached_o = (cnt_q == LIMIT_C);

endmodule

// File: rtl/wb_master_bridge.sv
// Single-transfer Wishbone classic master for the pipeline memory stage.
// Define WB_TIMEOUT_EN to add the TRAN-state bus watchdog and wbm_tout_o.
module wb_master_bridge
  import wb_pkg::*;
#(
  parameter  int DATA_W         = DATA_W_DEF,
  parameter  int ADDR_W         = ADDR_W_DEF,
  parameter  int TIMEOUT_CYCLES = 255,
  localparam int SEL_W          = sel_width(DATA_W)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] wbm_dat_i,
  input  logic [SEL_W-1:0]  wbm_sel_i,
  input  logic [ADDR_W-1:0] wbm_adr_i,
  input  logic              wbm_we_i,
  input  logic              wbm_re_i,
  input  logic              wbm_kill_i,
  output logic [DATA_W-1:0] wbm_dat_o,
  output logic              wbm_ack_o,
  output logic              wbm_err_o,
  output logic              wbm_cyc_o,
  output logic              wbm_tout_o,
  input  logic [DATA_W-1:0] wbs_dat_i,
  input  logic              wbs_ack_i,
  input  logic              wbs_err_i,
  output logic              wbs_cyc_o,
  output logic              wbs_stb_o,
  output logic              wbs_we_o,
  output logic [ADDR_W-1:0] wbs_adr_o,
  output logic [DATA_W-1:0] wbs_dat_o,
  output logic [SEL_W-1:0]  wbs_sel_o
);

  wb_state_e         state_q, state_d;
  logic              cyc_q, cyc_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [DATA_W-1:0] dat_q, dat_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [DATA_W-1:0] rdat_q, rdat_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic              tout_q, tout_d;
  logic              busy_q, busy_d;
  logic              tran_entry_s;
  logic              timeout_s;

`ifdef WB_TIMEOUT_EN
  wb_timeout_cnt #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (tran_entry_s),
    .en_i      (state_q == TRAN),
    .reached_o (timeout_s)
  );
`else
  assign timeout_s = 1'b0;
`endif

  // Next-state and next-output logic; ack/err/tout are pulses, so they default low.
  always_comb begin
    state_d      = state_q;
    cyc_d        = cyc_q;
    we_d         = we_q;
    adr_d        = adr_q;
    dat_d        = dat_q;
    sel_d        = sel_q;
    rdat_d       = rdat_q;
    ack_d        = 1'b0;
    err_d        = 1'b0;
    tout_d       = 1'b0;
    tran_entry_s = 1'b0;
    case (state_q)
      IDLE: begin
        if ((wbm_we_i || wbm_re_i) && !wbm_kill_i) begin
          adr_d = wbm_adr_i;
          dat_d = wbm_dat_i;
          sel_d = wbm_sel_i;
          we_d  = wbm_we_i;
          if (wbm_sel_i == '0) begin
            err_d   = 1'b1;
            state_d = ENDTRAN;
          end else begin
            cyc_d        = 1'b1;
            tran_entry_s = 1'b1;
            state_d      = TRAN;
          end
        end else begin
          state_d = IDLE;
        end
      end
      TRAN: begin
        // Kill outranks any same-cycle slave response, which is then discarded.
        if (wbm_kill_i) begin
          cyc_d   = 1'b0;
          state_d = IDLE;
        end else if (wbs_err_i) begin
          err_d   = 1'b1;
          cyc_d   = 1'b0;
          state_d = ENDTRAN;
        end else if (wbs_ack_i) begin
          ack_d   = 1'b1;
          cyc_d   = 1'b0;
          state_d = ENDTRAN;
          if (!we_q) begin
            rdat_d = wbs_dat_i;
          end else begin
            rdat_d = rdat_q;
          end
        end else if (timeout_s) begin
          err_d   = 1'b1;
          tout_d  = 1'b1;
          cyc_d   = 1'b0;
          state_d = ENDTRAN;
        end else begin
          state_d = TRAN;
        end
      end
      ENDTRAN: begin
        state_d = IDLE;
      end
      default: begin
        cyc_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      rdat_q  <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      tout_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      rdat_q  <= rdat_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      tout_q  <= tout_d;
      busy_q  <= busy_d;
    end
  end

  assign wbs_cyc_o  = cyc_q;
  assign wbs_stb_o  = cyc_q;
  assign wbs_we_o   = we_q;
  assign wbs_adr_o  = adr_q;
  assign wbs_dat_o  = dat_q;
  assign wbs_sel_o  = sel_q;
  assign wbm_dat_o  = rdat_q;
  assign wbm_ack_o  = ack_q;
  assign wbm_err_o  = err_q;
  assign wbm_tout_o = tout_q;
  assign wbm_cyc_o  = busy_q;

endmodule

// File: doc/wb_master_bridge.md
# wb_master_bridge

Parametrised Wishbone classic master that bridges the pipeline memory stage to the shared Wishbone bus. It latches one pipeline read or write request and runs exactly one Wishbone bus cycle for it. It returns one registered ack or err pulse with read data, and supports pipeline kill, a zero-byte-lane fault and an optional bus watchdog. It replaces the fixed 32-bit bridge and generalises data and address widths.

## Interface
- DATA_W, 32, data bus width; multiple of 8
- ADDR_W, 32, address width
- SEL_W, DATA_W/8, byte-select width (derived, not overridden)
- TIMEOUT_CYCLES, 255, watchdog limit in cycles spent in TRAN; must be ≥1
- clk_i  in  1  single clock, rising edge
- rst_i  in  1  reset, asynchronous, active-high
- wbm_dat_i  in  DATA_W  write data from pipeline
- wbm_sel_i  in  SEL_W  byte lanes
- wbm_adr_i  in  ADDR_W  address
- wbm_we_i  in  1  write request
- wbm_re_i  in  1  read request
- wbm_kill_i  in  1  abandon current/offered request
- wbm_dat_o  out  DATA_W  captured read data
- wbm_ack_o  out  1  one-cycle completion pulse
- wbm_err_o  out  1  one-cycle error pulse
- wbm_cyc_o  out  1  busy; high in TRAN and ENDTRAN
- wbm_tout_o  out  1  qualifies wbm_err_o as watchdog timeout (WB_TIMEOUT_EN only)
- wbs_dat_i  in  DATA_W  read data from slave
- wbs_ack_i  in  1  slave acknowledge
- wbs_err_i  in  1  slave error
- wbs_cyc_o, wbs_stb_o, wbs_we_o  out  1 each  bus cycle, strobe, write enable
- wbs_adr_o  out  ADDR_W; wbs_dat_o  out  DATA_W; wbs_sel_o  out  SEL_W  registered request

## Operation
- One-hot states: IDLE=3'b001, TRAN=3'b010, ENDTRAN=3'b100. All outputs are registered.
- Reset value of every output is 0, and the state is IDLE.
- IDLE:
  - A request is wbm_we_i|wbm_re_i with wbm_kill_i=0. On a request, latch adr, sel, we and dat; wbs_we_o=wbm_we_i. Write wins if both we and re are set.
  - If sel==0: no bus cycle; go to ENDTRAN with err.
  - Otherwise: cyc=stb=1, go to TRAN.
  - With kill=1 the request is ignored.
- TRAN: hold all wbs_* outputs stable until termination. Termination causes are:
  - err: wbs_err_i=1, which has priority over a simultaneous ack. Report err.
  - ack: wbs_ack_i=1 and err=0. On a read, capture wbs_dat_i into wbm_dat_o. Report ack.
  - timeout (macro on): the counter reaches TIMEOUT_CYCLES. Report err and set tout=1.
  - kill: wbm_kill_i=1. Drop cyc/stb and go to IDLE; report nothing. Kill wins over an ack or err in the same cycle, and the read data is not captured.
  - On ack/err/timeout: cyc=stb=0 and go to ENDTRAN.
- ENDTRAN: exactly one cycle. The ack or err pulse (and tout) is high, and kill is ignored. Next state is IDLE and the pulses clear.
- wbm_dat_o holds its value until the next successful read. Writes and errors leave it unchanged.
- Watchdog counter: TOUT_W=$clog2(TIMEOUT_CYCLES+1) bits. It clears on entry to TRAN, increments every TRAN cycle and saturates; there is no wrap.
- Asserting rst_i mid-cycle drops cyc/stb immediately and asynchronously, and no response is issued.

## Timing
- Request sampled at edge 0 → cyc/stb high after edge 0.
- Slave ack sampled at edge k (k≥1) → ENDTRAN after edge k, ack pulse for one cycle → IDLE after edge k+1.
- Minimum request-to-ack latency is 2 cycles. Minimum spacing between request accepts is 3 cycles.
- Zero-sel fault: err pulse in the cycle after acceptance, with no bus activity.
- Timeout: err pulse TIMEOUT_CYCLES+1 cycles after cyc rises.
- wbs_stb_o equals wbs_cyc_o at all times (classic, single transfer).

## Configuration
- WB_TIMEOUT_EN defined: the watchdog counter and wbm_tout_o exist, and timeout terminates the cycle as above.
- WB_TIMEOUT_EN undefined: no counter. wbm_tout_o is tied to 0 and TIMEOUT_CYCLES is unused. TRAN waits indefinitely for ack, err or kill.

## Structure
- Package wb_pkg holds:
  - the state localparams (IDLE, TRAN, ENDTRAN);
  - DATA_W and ADDR_W defaults;
  - a helper function for the SEL_W derivation.
- Sub-module wb_timeout_cnt: parametrised saturating counter with clear, enable and a reached flag. It is instantiated only under WB_TIMEOUT_EN.

## Test plan
- Read to adr 0x1000, sel 4'hF; slave acks on 3rd TRAN cycle with 0xDEADBEEF → one ack pulse, wbm_dat_o=0xDEADBEEF, cyc high for exactly 3 cycles.
- Write dat 0x12345678, sel 4'b0011; slave asserts ack and err together → err pulse only, no ack, wbm_dat_o unchanged.
- Read in flight, kill asserted in the same cycle as ack with data 0xAAAA5555 → cyc/stb drop, no ack/err, wbm_dat_o keeps its old value, back in IDLE.
- Request with sel=0 → no cyc/stb activity, err pulse 1 cycle after acceptance.
- WB_TIMEOUT_EN, TIMEOUT_CYCLES=4, slave never responds → err and tout pulse 5 cycles after cyc rise. Repeat without the macro → cyc stays high for 100 cycles, no err.
- Async rst_i pulse between edges during TRAN → all outputs 0 immediately. Then a new read with immediate ack → ack 2 cycles after request.
